btn_step_sequencer: RTL and testbench

Front-end controller that turns the raw east/west push-buttons into clean, one-at-a-time step commands for the board's signed saturating LED counter. It synchronizes and debounces both buttons, arbitrates simultaneous presses, and, when enabled, generates auto-repeat steps while a button is held. Commands go to the counter over a valid/ready handshake; the counter keeps ownership of the value and the saturation limits.

---
 rtl/btn_step_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_btn_step_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/btn_step_sequencer.sv
// btn_step_sequencer
//   Turns the raw east/west push-buttons into clean step commands for the
//   signed saturating LED counter. Each button passes through a 2-FF
//   synchronizer and its own debouncer. A small FSM arbitrates presses,
//   reports conflicts and hands one step at a time to the counter over a
//   valid/ready handshake.
//
//   Optional feature macro: AUTO_REPEAT_EN
//     defined   - a held button re-issues steps, first after REPEAT_DELAY
//                 cycles and then every REPEAT_PERIOD cycles. Each interval
//                 is counted from the acceptance of the previous step.
//     undefined - the repeat timer is not built; one press gives one step.
//
// Parameters
//   DEBOUNCE_CYCLES  stable-state flip threshold (cycles)
//   REPEAT_DELAY     acceptance of first step -> first repeat (>= 2)
//   REPEAT_PERIOD    acceptance of a repeat   -> next repeat  (>= 2)
//   CNT_W            width of the debounce and repeat counters
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   btn_east      raw button, press = decrement
//   btn_west      raw button, press = increment
//   step_valid    step command pending
//   step_dir      1 = increment, 0 = decrement; stable while step_valid
//   step_ready    counter accepts the command this cycle
//   busy          FSM is not idle
//   btn_conflict  one-cycle pulse when both buttons are pressed together
module btn_step_sequencer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int CNT_W           = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_east,
    input  logic btn_west,
    output logic step_valid,
    output logic step_dir,
    input  logic step_ready,
    output logic busy,
    output logic btn_conflict
);

    if (DEBOUNCE_CYCLES < 1 || (DEBOUNCE_CYCLES >> CNT_W) != 0 ||
        REPEAT_DELAY < 2 || (REPEAT_DELAY >> CNT_W) != 0 ||
        REPEAT_PERIOD < 2 || (REPEAT_PERIOD >> CNT_W) != 0) begin : g_param_check
        $error("btn_step_sequencer: counter parameters out of range for CNT_W");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD, WAIT_REL} state_t;

    // Bit 0 = east, bit 1 = west throughout.
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       stable_q, stable_d;
    logic [1:0]       prev_q;
    logic [CNT_W-1:0] db_cnt_q [2];
    logic [CNT_W-1:0] db_cnt_d [2];
    logic [1:0]       press;

    state_t state_q, state_d;
    logic   dir_q, dir_d;
    logic   conflict_q, conflict_d;
    logic   active_st, other_st;

    // ---- synchronizer + debouncer ----
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            prev_q   <= '0;
            for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q  <= {btn_west, btn_east};
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            for (int i = 0; i < 2; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    // The counter holds how many differing cycles have already been seen.
    // The flip is committed on the cycle after the count reaches
    // DEBOUNCE_CYCLES. This places the stable edge DEBOUNCE_CYCLES+2 edges
    // after the first raw sample.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES)) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign press     = stable_q & ~prev_q;
    assign active_st = dir_q ? stable_q[1] : stable_q[0];
    assign other_st  = dir_q ? stable_q[0] : stable_q[1];

    // ---- step FSM ----
`ifdef AUTO_REPEAT_EN
    logic [CNT_W-1:0] rpt_q, rpt_d;
    logic             first_q, first_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            dir_q      <= 1'b0;
            conflict_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rpt_q      <= '0;
            first_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            conflict_q <= conflict_d;
`ifdef AUTO_REPEAT_EN
            rpt_q      <= rpt_d;
            first_q    <= first_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        conflict_d = 1'b0;
`ifdef AUTO_REPEAT_EN
        rpt_d      = rpt_q;
        first_d    = first_q;
`endif
        case (state_q)
            IDLE: begin
                if (press[0] && press[1]) begin
                    conflict_d = 1'b1;
                    state_d    = WAIT_REL;
                end else if (press[1] || press[0]) begin
                    // The other stable value being high also covers a press
                    // on top of a button already held.
                    if ((press[1] && stable_q[0]) || (press[0] && stable_q[1])) begin
                        conflict_d = 1'b1;
                        state_d    = WAIT_REL;
                    end else begin
                        dir_d   = press[1];
                        state_d = ISSUE;
`ifdef AUTO_REPEAT_EN
                        first_d = 1'b1;
`endif
                    end
                end
            end
            ISSUE: begin
                if (step_ready) begin
                    state_d = HOLD;
`ifdef AUTO_REPEAT_EN
                    // Loaded with N-1: HOLD then spans N-1 cycles, so the
                    // next acceptance lands exactly N cycles after this one.
                    rpt_d   = first_q ? CNT_W'(REPEAT_DELAY - 1) : CNT_W'(REPEAT_PERIOD - 1);
                    first_d = 1'b0;
`endif
                end
            end
            HOLD: begin
                // Release wins over conflict, and conflict wins over expiry.
                if (!active_st) begin
                    state_d = IDLE;
                end else if (other_st) begin
                    conflict_d = 1'b1;
                    state_d    = WAIT_REL;
                end
`ifdef AUTO_REPEAT_EN
                else if (rpt_q <= CNT_W'(1)) begin
                    state_d = ISSUE;
                end else begin
                    rpt_d = rpt_q - CNT_W'(1);
                end
`endif
            end
            WAIT_REL: begin
                if (stable_q == 2'b00) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign step_valid   = (state_q == ISSUE);
    assign step_dir     = dir_q;
    assign busy         = (state_q != IDLE);
    assign btn_conflict = conflict_q;

endmodule

// File: tb/tb_btn_step_sequencer.sv
module tb_btn_step_sequencer;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;
    localparam int CW = 8;

    logic clk        = 1'b0;
    logic reset      = 1'b1;
    logic btn_east   = 1'b0;
    logic btn_west   = 1'b0;
    logic step_ready = 1'b1;
    logic step_valid, step_dir, busy, btn_conflict;

    always #5 clk = ~clk;

    btn_step_sequencer #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP),
        .CNT_W          (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_east    (btn_east),
        .btn_west    (btn_west),
        .step_valid  (step_valid),
        .step_dir    (step_dir),
        .step_ready  (step_ready),
        .busy        (busy),
        .btn_conflict(btn_conflict)
    );

    int total = 0;
    int bad   = 0;

    // One row = inputs driven before an edge, outputs expected just after it.
    typedef struct {
        logic rst, e, w, rdy;
        logic vld, dir, bsy, conf;
    } vec_t;

    vec_t vq[$];

    task automatic addn(input int n, input logic rst, input logic e, input logic w,
                        input logic rdy, input logic vld, input logic dir,
                        input logic bsy, input logic conf);
        vec_t v;
        v.rst = rst; v.e = e; v.w = w; v.rdy = rdy;
        v.vld = vld; v.dir = dir; v.bsy = bsy; v.conf = conf;
        repeat (n) vq.push_back(v);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset;
        reset      = 1'b1;
        btn_east   = 1'b0;
        btn_west   = 1'b0;
        step_ready = 1'b1;
        tick;
        tick;
        reset      = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int acc_c[$];
        int exp_acc[$];
        int conf_c[$];
        int dir_bad;
        int nv;
        logic b36, b37;

        // Reset held while west is pressed, then a 10-cycle west press.
        addn(2, 1, 0, 1, 1,  0, 0, 0, 0);
        addn(7, 0, 0, 1, 1,  0, 0, 0, 0);
        addn(1, 0, 0, 1, 1,  1, 1, 1, 0);
        addn(2, 0, 0, 1, 1,  0, 1, 1, 0);
        addn(7, 0, 0, 0, 1,  0, 1, 1, 0);
        addn(3, 0, 0, 0, 1,  0, 1, 0, 0);
        // Bouncing east input: never stable long enough.
        addn(2, 1, 0, 0, 1,  0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            addn(2, 0, 1, 0, 1,  0, 0, 0, 0);
            addn(2, 0, 0, 0, 1,  0, 0, 0, 0);
        end
        addn(8, 0, 0, 0, 1,  0, 0, 0, 0);
        // East press under backpressure: valid held 6 cycles, accepted once.
        addn(1, 1, 0, 0, 1,  0, 0, 0, 0);
        addn(7, 0, 1, 0, 1,  0, 0, 0, 0);
        addn(1, 0, 1, 0, 1,  1, 0, 1, 0);
        addn(5, 0, 1, 0, 0,  1, 0, 1, 0);
        addn(1, 0, 1, 0, 1,  0, 0, 1, 0);
        addn(7, 0, 0, 0, 1,  0, 0, 1, 0);
        addn(2, 0, 0, 0, 1,  0, 0, 0, 0);
        // Both rise together: one conflict pulse; busy until both released.
        addn(1, 1, 0, 0, 1,  0, 0, 0, 0);
        addn(7, 0, 1, 1, 1,  0, 0, 0, 0);
        addn(1, 0, 1, 1, 1,  0, 0, 1, 1);
        addn(2, 0, 1, 1, 1,  0, 0, 1, 0);
        addn(4, 0, 1, 0, 1,  0, 0, 1, 0);
        addn(7, 0, 0, 0, 1,  0, 0, 1, 0);
        addn(2, 0, 0, 0, 1,  0, 0, 0, 0);
        // Reset abandons a pending step; the held button is a fresh press.
        addn(1, 1, 0, 0, 1,  0, 0, 0, 0);
        addn(7, 0, 0, 1, 1,  0, 0, 0, 0);
        addn(2, 0, 0, 1, 0,  1, 1, 1, 0);
        addn(1, 1, 0, 1, 0,  0, 0, 0, 0);
        addn(7, 0, 0, 1, 1,  0, 0, 0, 0);
        addn(1, 0, 0, 1, 1,  1, 1, 1, 0);
        addn(1, 0, 0, 1, 1,  0, 1, 1, 0);

        foreach (vq[i]) begin
            reset      = vq[i].rst;
            btn_east   = vq[i].e;
            btn_west   = vq[i].w;
            step_ready = vq[i].rdy;
            tick;
            check($sformatf("vec%0d{vld,dir,busy,conf}", i),
                  {28'd0, step_valid, step_dir, busy, btn_conflict},
                  {28'd0, vq[i].vld, vq[i].dir, vq[i].bsy, vq[i].conf});
        end

        // West held 60 cycles: auto-repeat cadence, or a single step.
`ifdef AUTO_REPEAT_EN
        exp_acc = '{7, 27, 35, 43, 51, 59};
`else
        exp_acc = '{7};
`endif
        do_reset;
        dir_bad = 0;
        for (int c = 0; c < 80; c++) begin
            btn_west = (c < 60);
            tick;
            if (step_valid === 1'b1) begin
                acc_c.push_back(c);
                if (step_dir !== 1'b1) dir_bad++;
            end
        end
        check("hold_nsteps", acc_c.size(), exp_acc.size());
        for (int i = 0; i < exp_acc.size(); i++) begin
            check($sformatf("hold_step%0d_cycle", i),
                  (i < acc_c.size()) ? acc_c[i] : -1, exp_acc[i]);
        end
        check("hold_dir_errors", dir_bad, 0);
        check("hold_busy_end", {31'd0, busy}, 0);

        // East pressed on top of a held west step: conflict from HOLD.
        do_reset;
        nv  = 0;
        b36 = 1'bx;
        b37 = 1'bx;
        for (int c = 0; c < 50; c++) begin
            btn_west = (c < 30);
            btn_east = (c >= 12 && c < 30);
            tick;
            if (step_valid === 1'b1) nv++;
            if (btn_conflict === 1'b1) conf_c.push_back(c);
            if (c == 36) b36 = busy;
            if (c == 37) b37 = busy;
        end
        check("holdconf_nsteps", nv, 1);
        check("holdconf_npulses", conf_c.size(), 1);
        check("holdconf_pulse_cycle", (conf_c.size() > 0) ? conf_c[0] : -1, 19);
        check("holdconf_busy_c36", {31'd0, b36}, 1);
        check("holdconf_busy_c37", {31'd0, b37}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
